// File: rtl/prio_encoder_q.sv
// Pending-request priority encoder with a one-deep code output register.
// Requests accumulate in a pending set; one encoded index is presented at a time under valid/ready.
module prio_encoder_q #(
   parameter int N           = 8,
   parameter int W           = $clog2(N),
   parameter bit ROUND_ROBIN = 1'b0,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         flush,
   output logic [W-1:0] code,
   output logic         code_valid,
   input  logic         code_ready,
   output logic         multi,
   output logic [N-1:0] pending,
   output logic [7:0]   drop_cnt
);

   // Handshake: a code transfers on a rising edge where code_valid and code_ready are both 1;
   // code and multi stay stable while code_valid=1 and code_ready=0.
   typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

   state_t       state, state_nxt;
   logic [W-1:0] ptr;
   logic         accept;
   logic         load;
   logic [N-1:0] clr;
   logic [N-1:0] cand;
   logic [W-1:0] sel_idx;
   logic [W-1:0] hi_idx;
   logic [W-1:0] lo_idx;
   logic         hi_found;
   logic [7:0]   coal_cnt;
   logic [8:0]   drop_sum;

   function automatic logic [7:0] popcnt(input logic [N-1:0] v);
      logic [7:0] cnt;
      cnt = '0;
      for (int i = 0; i < N; i++) cnt = cnt + 8'(v[i]);
      return cnt;
   endfunction

   assign code_valid = (state == PRESENT);
   assign accept     = code_valid & code_ready;
   assign clr        = accept ? ({{(N-1){1'b0}}, 1'b1} << code) : '0;
   assign cand       = pending & ~clr;
   assign load       = (state == IDLE) | accept;
   assign coal_cnt   = popcnt(req & cand);
   assign drop_sum   = {1'b0, drop_cnt} + {1'b0, coal_cnt};

   // Round-robin: first candidate at or above ptr, else wrap to the lowest candidate.
   always_comb begin
      sel_idx  = '0;
      hi_idx   = '0;
      lo_idx   = '0;
      hi_found = 1'b0;
      if (ROUND_ROBIN) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
               lo_idx = W'(i);
               if (i >= int'(ptr)) begin
                  hi_idx   = W'(i);
                  hi_found = 1'b1;
               end
            end
         end
         sel_idx = hi_found ? hi_idx : lo_idx;
      end else if (MSB_FIRST) begin
         for (int i = 0; i < N; i++) if (cand[i]) sel_idx = W'(i);
      end else begin
         for (int i = N - 1; i >= 0; i--) if (cand[i]) sel_idx = W'(i);
      end
   end

   always_comb begin
      state_nxt = state;
      if (load) state_nxt = (cand != '0) ? PRESENT : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     state <= IDLE;
      else if (flush) state <= IDLE;
      else            state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         code     <= '0;
         multi    <= 1'b0;
         ptr      <= '0;
         drop_cnt <= '0;
      end else if (flush) begin
         pending  <= '0;
         ptr      <= '0;
         drop_cnt <= '0;
      end else begin
         pending  <= cand | req;
         drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
         if (load && (cand != '0)) begin
            code  <= sel_idx;
            multi <= (popcnt(cand) > 8'd1);
         end
         if (accept) ptr <= (code == W'(N - 1)) ? '0 : code + W'(1);
      end
   end

endmodule

// File: tb/tb_prio_encoder_q.sv
// Bench for prio_encoder_q: fixed MSB-first, fixed LSB-first and round-robin instances share one stimulus stream.
module tb_prio_encoder_q;
   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic         flush = 1'b0;
   logic         code_ready = 1'b0;

   logic [W-1:0] code_o  [3];
   logic         valid_o [3];
   logic         multi_o [3];
   logic [N-1:0] pend_o  [3];
   logic [7:0]   drop_o  [3];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   prio_encoder_q #(.N(N), .ROUND_ROBIN(1'b0), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .req(req), .flush(flush), .code(code_o[0]),
      .code_valid(valid_o[0]), .code_ready(code_ready), .multi(multi_o[0]),
      .pending(pend_o[0]), .drop_cnt(drop_o[0]));
   prio_encoder_q #(.N(N), .ROUND_ROBIN(1'b0), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .req(req), .flush(flush), .code(code_o[1]),
      .code_valid(valid_o[1]), .code_ready(code_ready), .multi(multi_o[1]),
      .pending(pend_o[1]), .drop_cnt(drop_o[1]));
   prio_encoder_q #(.N(N), .ROUND_ROBIN(1'b1), .MSB_FIRST(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n), .req(req), .flush(flush), .code(code_o[2]),
      .code_valid(valid_o[2]), .code_ready(code_ready), .multi(multi_o[2]),
      .pending(pend_o[2]), .drop_cnt(drop_o[2]));

   // Reference model: pending set as a byte, selection by scanning indices in arbitration order.
   logic [7:0] m_p     [3] = '{default: '0};
   bit         m_valid [3] = '{default: 1'b0};
   bit         m_multi [3] = '{default: 1'b0};
   int         m_code  [3] = '{default: 0};
   int         m_ptr   [3] = '{default: 0};
   int         m_drop  [3] = '{default: 0};

   function automatic int pick(input int c, input logic [7:0] s, input int ptr);
      int r;
      r = 0;
      if (c == 0) begin
         for (int i = 0; i < 8; i++) if (s[i]) r = i;
      end else if (c == 1) begin
         for (int i = 7; i >= 0; i--) if (s[i]) r = i;
      end else begin
         for (int k = 7; k >= 0; k--) if (s[(ptr + k) % 8]) r = (ptr + k) % 8;
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      logic [7:0] s;
      bit         acc;
      int         old;
      for (int c = 0; c < 3; c++) begin
         if (!rst_n) begin
            m_p[c] = '0; m_valid[c] = 0; m_multi[c] = 0;
            m_code[c] = 0; m_ptr[c] = 0; m_drop[c] = 0;
         end else if (flush) begin
            m_p[c] = '0; m_valid[c] = 0; m_ptr[c] = 0; m_drop[c] = 0;
         end else begin
            acc = m_valid[c] && code_ready;
            s   = m_p[c];
            if (acc) s[m_code[c]] = 1'b0;
            m_drop[c] = m_drop[c] + $countones(req & s);
            if (m_drop[c] > 255) m_drop[c] = 255;
            old = m_code[c];
            if (!m_valid[c] || acc) begin
               if (s != 0) begin
                  m_code[c]  = pick(c, s, m_ptr[c]);
                  m_multi[c] = ($countones(s) > 1);
                  m_valid[c] = 1;
               end else begin
                  m_valid[c] = 0;
               end
            end
            if (acc) m_ptr[c] = (old + 1) % 8;
            m_p[c] = s | req;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      for (int c = 0; c < 3; c++) begin
         check($sformatf("c%0d_valid", c), 32'(valid_o[c]), 32'(m_valid[c]));
         check($sformatf("c%0d_code", c),  32'(code_o[c]),  32'(m_code[c]));
         check($sformatf("c%0d_multi", c), 32'(multi_o[c]), 32'(m_multi[c]));
         check($sformatf("c%0d_pend", c),  32'(pend_o[c]),  32'(m_p[c]));
         check($sformatf("c%0d_drop", c),  32'(drop_o[c]),  32'(m_drop[c]));
      end
   endtask

   task automatic check_zero(input string tag);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("%s_c%0d_valid", tag, c), 32'(valid_o[c]), 32'd0);
         check($sformatf("%s_c%0d_code", tag, c),  32'(code_o[c]),  32'd0);
         check($sformatf("%s_c%0d_multi", tag, c), 32'(multi_o[c]), 32'd0);
         check($sformatf("%s_c%0d_pend", tag, c),  32'(pend_o[c]),  32'd0);
         check($sformatf("%s_c%0d_drop", tag, c),  32'(drop_o[c]),  32'd0);
      end
   endtask

   task automatic step(input logic [7:0] r, input bit rd, input bit fl);
      req        = r;
      code_ready = rd;
      flush      = fl;
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   typedef struct {
      logic [7:0] req;
      bit         rdy;
      bit         fl;
      int         code;
      bit         valid;
      bit         multi;
      logic [7:0] pend;
      int         drop;
   } vec_t;

   vec_t tbl [25];

   initial begin
      // Expected outputs of the MSB-first instance after each edge.
      tbl[0]  = '{8'h04, 1, 0, 2'd0, 0, 0, 8'h04, 0};
      tbl[1]  = '{8'h00, 1, 0, 2,    1, 0, 8'h04, 0};
      tbl[2]  = '{8'h00, 1, 0, 2,    0, 0, 8'h00, 0};
      tbl[3]  = '{8'h81, 1, 0, 2,    0, 0, 8'h81, 0};
      tbl[4]  = '{8'h00, 1, 0, 7,    1, 1, 8'h81, 0};
      tbl[5]  = '{8'h00, 1, 0, 0,    1, 0, 8'h01, 0};
      tbl[6]  = '{8'h00, 1, 0, 0,    0, 0, 8'h00, 0};
      tbl[7]  = '{8'h08, 0, 0, 0,    0, 0, 8'h08, 0};
      tbl[8]  = '{8'h00, 0, 0, 3,    1, 0, 8'h08, 0};
      tbl[9]  = '{8'h10, 0, 0, 3,    1, 0, 8'h18, 0};
      tbl[10] = '{8'h00, 0, 0, 3,    1, 0, 8'h18, 0};
      tbl[11] = '{8'h00, 0, 0, 3,    1, 0, 8'h18, 0};
      tbl[12] = '{8'h00, 0, 0, 3,    1, 0, 8'h18, 0};
      tbl[13] = '{8'h00, 1, 0, 4,    1, 0, 8'h10, 0};
      tbl[14] = '{8'h00, 1, 0, 4,    0, 0, 8'h00, 0};
      tbl[15] = '{8'h01, 0, 0, 4,    0, 0, 8'h01, 0};
      tbl[16] = '{8'h01, 0, 0, 0,    1, 0, 8'h01, 1};
      tbl[17] = '{8'h01, 0, 0, 0,    1, 0, 8'h01, 2};
      tbl[18] = '{8'hFF, 0, 1, 0,    0, 0, 8'h00, 0};
      tbl[19] = '{8'h00, 1, 0, 0,    0, 0, 8'h00, 0};
      tbl[20] = '{8'h02, 1, 0, 0,    0, 0, 8'h02, 0};
      tbl[21] = '{8'h02, 1, 0, 1,    1, 0, 8'h02, 1};
      tbl[22] = '{8'h02, 1, 0, 1,    0, 0, 8'h02, 1};
      tbl[23] = '{8'h00, 1, 0, 1,    1, 0, 8'h02, 1};
      tbl[24] = '{8'h00, 1, 0, 1,    0, 0, 8'h00, 1};

      #1;
      check_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_zero("post_release");

      for (int i = 0; i < 25; i++) begin
         step(tbl[i].req, tbl[i].rdy, tbl[i].fl);
         check($sformatf("tbl%0d_valid", i), 32'(valid_o[0]), 32'(tbl[i].valid));
         check($sformatf("tbl%0d_code", i),  32'(code_o[0]),  32'(tbl[i].code));
         check($sformatf("tbl%0d_multi", i), 32'(multi_o[0]), 32'(tbl[i].multi));
         check($sformatf("tbl%0d_pend", i),  32'(pend_o[0]),  32'(tbl[i].pend));
         check($sformatf("tbl%0d_drop", i),  32'(drop_o[0]),  32'(tbl[i].drop));
         if (i == 4) check("lsb_first_code", 32'(code_o[1]), 32'd0);
         if (i == 5) check("lsb_second_code", 32'(code_o[1]), 32'd7);
      end

      // Round-robin over a held full request vector: no gaps, pointer wraps.
      step(8'h00, 1, 1);
      step(8'hFF, 1, 0);
      for (int j = 0; j < 10; j++) begin
         step(8'hFF, 1, 0);
         check($sformatf("rr%0d_valid", j), 32'(valid_o[2]), 32'd1);
         check($sformatf("rr%0d_code", j),  32'(code_o[2]),  32'(j % 8));
      end

      // Coalescing saturates at 255.
      step(8'h00, 0, 1);
      for (int j = 0; j < 300; j++) step(8'h01, 0, 0);
      for (int c = 0; c < 3; c++)
         check($sformatf("sat_c%0d_drop", c), 32'(drop_o[c]), 32'd255);

      // Asynchronous reset while a code is presented.
      req = 8'h00;
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_zero("rst_hold");
      step(8'h00, 1, 0);
      check("rst_discard_valid", 32'(valid_o[0]), 32'd0);
      step(8'h20, 1, 0);
      step(8'h00, 1, 0);
      check("after_rst_code", 32'(code_o[0]), 32'd5);

      for (int j = 0; j < 400; j++) begin
         logic [7:0] r;
         r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
